// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, runtime bit period, mid-bit sampling,
// start-bit glitch rejection and stop-bit framing check with a one-cycle done strobe.
module uart_rx #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [12:0]           CLKS_PER_BIT,
    input  logic                  rx_bit,
    output logic [data_width-1:0] data_out,
    output logic                  done,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int BCW = $clog2(data_width);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    state_t                state_q;
    logic                  rx_meta_q;
    logic                  rx_s_q;
    logic                  armed_q;
    logic [12:0]           clk_cnt_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [data_width-1:0] shift_q;
    logic [data_width-1:0] data_q;
    logic                  frame_err_q;

    logic [12:0]           last_cnt;
    logic [12:0]           half_cnt;

    assign last_cnt = CLKS_PER_BIT - 13'd1;
    assign half_cnt = last_cnt >> 1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            armed_q     <= 1'b0;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_bit;
            rx_s_q    <= rx_meta_q;

            case (state_q)
                // armed only rises on a high line, so a held-low break cannot retrigger
                IDLE: begin
                    if (rx_s_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q   <= START_BIT;
                        clk_cnt_q <= '0;
                    end
                end

                START_BIT: begin
                    if (clk_cnt_q == half_cnt) begin
                        if (!rx_s_q) begin
                            state_q   <= DATA_BITS;
                            clk_cnt_q <= '0;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 13'd1;
                    end
                end

                DATA_BITS: begin
                    if (clk_cnt_q == last_cnt) begin
                        shift_q[bit_cnt_q] <= rx_s_q;
                        clk_cnt_q          <= '0;
                        if (bit_cnt_q == BCW'(data_width - 1)) begin
                            state_q <= STOP_BIT;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 13'd1;
                    end
                end

                STOP_BIT: begin
                    if (clk_cnt_q == last_cnt) begin
                        if (rx_s_q) begin
                            data_q      <= shift_q;
                            frame_err_q <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            armed_q     <= 1'b0;
                        end
                        state_q <= DONE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 13'd1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign frame_err = frame_err_q;
    assign done      = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner sequences,
// with a scoreboard of expected bytes, framing flags and done cycles.
module tb_uart_rx;

    logic        clk;
    logic        rstn;
    logic [12:0] clks_per_bit;
    logic        rx_bit;
    logic [7:0]  data_out;
    logic        done;
    logic        frame_err;
    logic        busy;

    uart_rx #(.data_width(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .CLKS_PER_BIT(clks_per_bit),
        .rx_bit      (rx_bit),
        .data_out    (data_out),
        .done        (done),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [12:0] n;
        logic [7:0]  data;
        int          gap;
        logic [7:0]  exp_data;
        logic        exp_fe;
    } vec_t;

    exp_t sb[$];
    int   done_cycles[$];
    int   errors = 0;
    int   checks = 0;
    logic prev_done = 1'b0;
    exp_t e_mon;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest expected frame.
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_done) begin
                check("done_one_cycle", {31'd0, done}, 32'd0);
                check("busy_after_done", {31'd0, busy}, 32'd0);
            end
            if (done) begin
                done_cycles.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done=1 at cycle %0d, required no done", cyc);
                end else begin
                    e_mon = sb.pop_front();
                    check("data_out", {24'd0, data_out}, {24'd0, e_mon.data});
                    check("frame_err", {31'd0, frame_err}, {31'd0, e_mon.fe});
                    check("done_cycle", cyc, e_mon.cyc);
                end
            end
        end
        prev_done = done;
    end

    // Drives start, 8 data bits LSB first and the stop bit; leaves the line at the stop value.
    task automatic drive_bits(input logic [12:0] n, input logic [7:0] d, input logic stop,
                              input bit push, input logic [7:0] exp_d, input logic exp_fe);
        int k;
        int h;
        exp_t e;
        clks_per_bit = n;
        rx_bit = 1'b0;
        k = cyc + 1;
        h = (int'(n) - 1) >> 1;
        if (push) begin
            e.data = exp_d;
            e.fe   = exp_fe;
            e.cyc  = k + 3 + h + 9 * int'(n);
            sb.push_back(e);
        end
        repeat (int'(n)) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bit = d[i];
            repeat (int'(n)) @(negedge clk);
        end
        rx_bit = stop;
        repeat (int'(n)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [12:0] n, input logic [7:0] d, input int gap,
                              input logic [7:0] exp_d, input logic exp_fe);
        drive_bits(n, d, 1'b1, 1'b1, exp_d, exp_fe);
        rx_bit = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{13'd16,  8'hA5, 20, 8'hA5, 1'b0};
        tbl[1]  = '{13'd16,  8'h00, 0,  8'h00, 1'b0};
        tbl[2]  = '{13'd16,  8'hFF, 20, 8'hFF, 1'b0};
        tbl[3]  = '{13'd4,   8'h00, 3,  8'h00, 1'b0};
        tbl[4]  = '{13'd4,   8'h55, 3,  8'h55, 1'b0};
        tbl[5]  = '{13'd4,   8'h80, 3,  8'h80, 1'b0};
        tbl[6]  = '{13'd4,   8'hFF, 10, 8'hFF, 1'b0};
        tbl[7]  = '{13'd434, 8'h00, 10, 8'h00, 1'b0};
        tbl[8]  = '{13'd434, 8'h55, 10, 8'h55, 1'b0};
        tbl[9]  = '{13'd434, 8'h80, 10, 8'h80, 1'b0};
        tbl[10] = '{13'd434, 8'hFF, 20, 8'hFF, 1'b0};

        rstn = 1'b0;
        rx_bit = 1'b1;
        clks_per_bit = 13'd16;
        repeat (3) @(negedge clk);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            send_frame(tbl[i].n, tbl[i].data, tbl[i].gap, tbl[i].exp_data, tbl[i].exp_fe);
        end

        // Back-to-back 0x00 then 0xFF: strobes one frame (10 bits of 16 cycles) apart.
        if (done_cycles.size() >= 3) begin
            check("b2b_spacing", done_cycles[2] - done_cycles[1], 32'd160);
        end else begin
            checks++;
            errors++;
            $display("FAIL b2b_spacing: only %0d done strobes seen, required at least 3", done_cycles.size());
        end

        // Start-bit glitch: three low cycles are rejected, then a real frame.
        clks_per_bit = 13'd16;
        rx_bit = 1'b0;
        repeat (3) @(negedge clk);
        rx_bit = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_data_out", {24'd0, data_out}, 32'hFF);
        send_frame(13'd16, 8'h3C, 20, 8'h3C, 1'b0);

        // Framing error, line held low afterwards must not retrigger.
        drive_bits(13'd16, 8'h5A, 1'b0, 1'b1, 8'h3C, 1'b1);
        repeat (40) @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'd0);
        check("break_data_out", {24'd0, data_out}, 32'h3C);
        rx_bit = 1'b1;
        repeat (20) @(negedge clk);

        // Reset during data bit 4 aborts the frame without a done.
        rx_bit = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_bit = i[0] ? 1'b0 : 1'b1;
            repeat (16) @(negedge clk);
        end
        rx_bit = 1'b0;
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("midrst_data_out", {24'd0, data_out}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rx_bit = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(13'd16, 8'hC3, 20, 8'hC3, 1'b0);
        check("after_rst_data_out", {24'd0, data_out}, 32'hC3);

        repeat (50) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("done_count", done_cycles.size(), 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Consumes the serial line driven by the team's UART transmitter, either on-chip loopback or the board RX pin, and delivers received bytes to the command/data path.
- Runtime-programmable bit period. Mid-bit sampling, start-bit glitch rejection, stop-bit framing check.
- Single-cycle `done` strobe per byte.

Parameters:
- data_width, 8, number of data bits per frame (LSB first). Only 8 is supported.

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous active-low reset
- CLKS_PER_BIT  input  13  clock cycles per bit, N; legal range 4..8191; must be stable for a whole frame
- rx_bit  input  1  asynchronous serial line, idle high
- data_out  output  8  last correctly framed byte; held until the next good frame
- done  output  1  one-cycle strobe at frame end (good or bad)
- frame_err  output  1  valid only with done; 1 = stop bit sampled low
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE, both synchronizer flops = 1, armed = 0, clk_counter = 0, bit_counter = 0, shift = 0, data_out = 0, done = 0, frame_err = 0, busy = 0.
- Synchronizer: rx_bit passes through 2 flops to give rx_s. All decisions use rx_s only.
- Definitions: H = (N-1)>>1, 13-bit. clk_counter is 13-bit and compares against N-1 computed in 13 bits.
- IDLE:
  - armed <= 1 when rx_s = 1.
  - If armed = 1 and rx_s = 0: go to START_BIT, clk_counter <= 0.
  - armed prevents a line held low (break or framing error) from retriggering.
- START_BIT:
  - Increment clk_counter until it equals H.
  - At clk_counter == H: if rx_s = 0, go to DATA_BITS with clk_counter <= 0 and bit_counter <= 0.
  - Otherwise go to IDLE (glitch), with no done and armed kept 1.
- DATA_BITS:
  - Increment clk_counter until it equals N-1.
  - At N-1: shift[bit_counter] <= rx_s and clk_counter <= 0.
  - If bit_counter == 7, go to STOP_BIT; else bit_counter <= bit_counter + 1.
- STOP_BIT:
  - Count to N-1.
  - At N-1: if rx_s = 1, data_out <= shift and frame_err <= 0.
  - If rx_s = 0, frame_err <= 1, data_out unchanged, armed <= 0.
  - Go to DONE.
- DONE:
  - done = 1 for exactly one cycle, then go to IDLE.
  - frame_err holds its value until the next DONE.
- Outputs are registered or decoded from the state register only. There is no combinational path from rx_bit.
- Latency: let k be the first clk edge at which rx_bit is sampled 0. The state enters DONE at edge k+3+H+9N, so done is high in the cycle after that edge. Example: N=16 gives k+154.
- Sample points:
  - Start bit is checked about mid-bit.
  - Each data bit and the stop bit are sampled N cycles after the previous sample, i.e. about mid-bit.
- Line activity during DONE is ignored. A new start bit may be detected from the IDLE cycle that follows.
- Reset mid-frame aborts immediately to reset values. No done is generated.
- A CLKS_PER_BIT change mid-frame is undefined. Values below 4 are unsupported.

Test Plan:
- Good byte: N=16, send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) -> done one cycle at k+154, data_out=0xA5, frame_err=0, busy low the cycle after done.
- Back-to-back: N=16, 0x00 then 0xFF with no idle gap (stop bit directly followed by start) -> two done strobes 160 cycles apart, data_out 0x00 then 0xFF, frame_err=0 both.
- Glitch: N=16, rx_bit low for 3 cycles then high -> returns to IDLE, no done, data_out unchanged; a following 0x3C frame is received correctly.
- Framing error: N=16, send 0x5A with stop bit 0 and line held low for 40 further cycles -> done with frame_err=1, data_out keeps previous value. No new frame starts until the line returns high and then falls again.
- Reset mid-frame: rstn=0 for 1 cycle during bit 4 of a frame -> all outputs at reset values next cycle, no done. The next full frame 0xC3 is received with data_out=0xC3.
- Loopback with transmitter, N=4 and N=434: send 0x00, 0x55, 0x80, 0xFF -> each received byte equals the sent byte, frame_err=0, no spurious done.
